// File: rtl/inv_key_expansion.sv
// inv_key_expansion: AES-128 key schedule that expands forward to round 10, then steps back one round key per request
// Ports: CLK clock, RST sync active-high reset, start/key load the cipher key and begin expansion,
//        step requests the previous round key, rk/round current round key and its index,
//        rk_valid key usable, busy expanding, done back at round 0, key_err self-check mismatch.
// Optional: define INV_KEY_EXPANSION_SELFCHECK_EN to store the key and flag a mismatch on returning to round 0.
module inv_key_expansion (
   input  logic         CLK,
   input  logic         RST,
   input  logic         start,
   input  logic [127:0] key,
   input  logic         step,
   output logic [127:0] rk,
   output logic [3:0]   round,
   output logic         rk_valid,
   output logic         busy,
   output logic         done,
   output logic         key_err
);
   typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? p ^ x : p;
         x = x[7] ? {x[6:0], 1'b0} ^ 8'h1b : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse, and maps 0 to 0 without a special case
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < 7; i++) r = gf_mul(gf_mul(r, r), a);
      return gf_mul(r, r);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x;
      x = gf_inv(a);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      return i == 4'd8 ? 8'h1b : i == 4'd9 ? 8'h36 : 8'(8'h01 << i);
   endfunction

   state_t       r_state;
   logic [127:0] r_rk;
   logic [3:0]   r_round;
   logic         r_valid;
   logic         r_busy;

   logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_t, w_rot, w_sub;
   logic [3:0]   w_ri;
   logic         w_back, w_step;
   logic [127:0] w_fwd, w_bwd;

   assign {w_w0, w_w1, w_w2, w_w3} = r_rk;
   // One SubWord serves both directions: backward needs the previous w3, which is n3^n2
   assign w_back = r_state == READY;
   assign w_t    = w_back ? w_w3 ^ w_w2 : w_w3;
   assign w_ri   = w_back ? r_round - 4'd1 : r_round;
   assign w_rot  = {w_t[23:0], w_t[31:24]};
   assign w_sub  = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])}
                   ^ {rcon(w_ri), 24'h0};
   assign w_fwd  = {w_w0 ^ w_sub, w_w1 ^ w_w0 ^ w_sub, w_w2 ^ w_w1 ^ w_w0 ^ w_sub,
                    w_w3 ^ w_w2 ^ w_w1 ^ w_w0 ^ w_sub};
   assign w_bwd  = {w_w0 ^ w_sub, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};
   assign w_step = w_back && step && r_round != 4'd0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_rk    <= '0;
         r_round <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else if (start) begin
         r_state <= EXPAND;
         r_rk    <= key;
         r_round <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b1;
      end else if (r_state == EXPAND) begin
         r_rk    <= w_fwd;
         r_round <= r_round + 4'd1;
         if (r_round == 4'd9) begin
            r_state <= READY;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
         end
      end else if (w_step) begin
         r_rk    <= w_bwd;
         r_round <= r_round - 4'd1;
      end
   end

`ifdef INV_KEY_EXPANSION_SELFCHECK_EN
   logic [127:0] r_key;
   logic         r_err;
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_key <= '0;
         r_err <= 1'b0;
      end else if (start) begin
         r_key <= key;
         r_err <= 1'b0;
      end else if (w_step && r_round == 4'd1 && w_bwd != r_key) begin
         r_err <= 1'b1;
      end
   end
   assign key_err = r_err;
`else
   assign key_err = 1'b0;
`endif

   assign rk       = r_rk;
   assign round    = r_round;
   assign rk_valid = r_valid;
   assign busy     = r_busy;
   assign done     = r_state == READY && r_round == 4'd0;
endmodule
